// File: rtl/stack_unit_if.sv
// Operation/status bundle between the stack CPU core and one stack_unit.
// The master side issues ops and reads back the cached top entries and status.
interface stack_unit_if #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 64
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic             op_ready;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [PW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output op_valid, op, din, err_clr,
        input  op_ready, tos, nos, depth, empty, full, ovf, unf
    );

    modport slave (
        input  op_valid, op, din, err_clr,
        output op_ready, tos, nos, depth, empty, full, ovf, unf
    );
endinterface

// File: rtl/stack_unit.sv
// One-op-per-clock hardware stack: TOS/NOS cached in registers, deeper entries
// in a register array, sticky overflow/underflow that stalls until err_clr.
module stack_unit #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 64,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         rst,
    stack_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] L_FULL = PW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_DUP  = 3'b011,
        OP_SWAP = 3'b100,
        OP_OVER = 3'b101,
        OP_REPL = 3'b110,
        OP_BIN  = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_mem [DEPTH-2];
    logic [WIDTH-1:0] r_tos;
    logic [WIDTH-1:0] r_nos;
    logic [PW-1:0]    r_depth;
    logic             r_ovf;
    logic             r_unf;

    logic             w_fire;
    logic [PW-1:0]    w_ptr;
    logic [AW-1:0]    w_idx;
    logic [WIDTH-1:0] w_arr_top;
    logic             w_push;
    logic [WIDTH-1:0] w_push_val;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_wr;
    logic [WIDTH-1:0] w_tos_n;
    logic [WIDTH-1:0] w_nos_n;
    logic [PW-1:0]    w_depth_n;
    op_e              w_op;

    assign w_op   = op_e'(bus.op);
    assign w_fire = bus.op_valid & ~(r_ovf | r_unf);
    assign w_ptr  = (r_depth >= PW'(2)) ? (r_depth - PW'(2)) : '0;
    assign w_idx  = w_ptr[AW-1:0];
    // Third entry from the top sits just below the pointer; it refills NOS on pops.
    assign w_arr_top = (r_depth >= PW'(3)) ? r_mem[w_idx - AW'(1)] : '0;

    always_comb begin
        w_push     = 1'b0;
        w_push_val = '0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_wr       = 1'b0;
        w_tos_n    = r_tos;
        w_nos_n    = r_nos;
        w_depth_n  = r_depth;
        if (w_fire) begin
            unique case (w_op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (r_depth == L_FULL) w_set_ovf = 1'b1;
                    else begin
                        w_push     = 1'b1;
                        w_push_val = bus.din;
                    end
                end
                OP_DUP: begin
                    if (r_depth == '0) w_set_unf = 1'b1;
                    else if (r_depth == L_FULL) w_set_ovf = 1'b1;
                    else begin
                        w_push     = 1'b1;
                        w_push_val = r_tos;
                    end
                end
                OP_OVER: begin
                    if (r_depth < PW'(2)) w_set_unf = 1'b1;
                    else if (r_depth == L_FULL) w_set_ovf = 1'b1;
                    else begin
                        w_push     = 1'b1;
                        w_push_val = r_nos;
                    end
                end
                OP_POP: begin
                    if (r_depth == '0) w_set_unf = 1'b1;
                    else begin
                        w_tos_n   = r_nos;
                        w_nos_n   = w_arr_top;
                        w_depth_n = r_depth - PW'(1);
                    end
                end
                OP_SWAP: begin
                    if (r_depth < PW'(2)) w_set_unf = 1'b1;
                    else begin
                        w_tos_n = r_nos;
                        w_nos_n = r_tos;
                    end
                end
                OP_REPL: begin
                    if (r_depth == '0) w_set_unf = 1'b1;
                    else w_tos_n = bus.din;
                end
                OP_BIN: begin
                    if (r_depth < PW'(2)) w_set_unf = 1'b1;
                    else begin
                        w_tos_n   = bus.din;
                        w_nos_n   = w_arr_top;
                        w_depth_n = r_depth - PW'(1);
                    end
                end
                default: ;
            endcase
        end
        if (w_push) begin
            w_wr      = (r_depth >= PW'(2));
            w_nos_n   = r_tos;
            w_tos_n   = w_push_val;
            w_depth_n = r_depth + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tos   <= '0;
            r_nos   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_tos   <= w_tos_n;
            r_nos   <= w_nos_n;
            r_depth <= w_depth_n;
            // A new violation wins over a simultaneous clear.
            r_ovf   <= w_set_ovf | (r_ovf & ~bus.err_clr);
            r_unf   <= w_set_unf | (r_unf & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) r_mem[w_idx] <= r_nos;
    end

    assign bus.op_ready = ~(r_ovf | r_unf);
    assign bus.tos      = r_tos;
    assign bus.nos      = r_nos;
    assign bus.depth    = r_depth;
    assign bus.empty    = (r_depth == '0);
    assign bus.full     = (r_depth == L_FULL);
    assign bus.ovf      = r_ovf;
    assign bus.unf      = r_unf;
endmodule

// File: tb/tb_stack_unit.sv
// Directed plus short random bench for stack_unit against a queue-based stack model.
module tb_stack_unit;
    localparam int W  = 36;
    localparam int D  = 8;
    localparam int PW = $clog2(D) + 1;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                           SWAP = 3'd4, OVER = 3'd5, REPL = 3'd6, BIN = 3'd7;

    typedef struct {
        logic [W-1:0]  tos;
        logic [W-1:0]  nos;
        logic [PW-1:0] depth;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
        logic          rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [W-1:0] m_stk[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    exp_t         sb[$];

    stack_unit_if #(.WIDTH(W), .DEPTH(D)) ifc ();
    stack_unit #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        int n = m_stk.size();
        e.tos   = (n >= 1) ? m_stk[n-1] : '0;
        e.nos   = (n >= 2) ? m_stk[n-2] : '0;
        e.depth = PW'(n);
        e.empty = (n == 0);
        e.full  = (n == D);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.rdy   = !(m_ovf || m_unf);
        return e;
    endfunction

    task automatic model_step(input logic [2:0] o, input logic [W-1:0] d, input bit clr);
        int n = m_stk.size();
        bit so = 1'b0;
        bit su = 1'b0;
        logic [W-1:0] t;
        if (!(m_ovf || m_unf)) begin
            case (o)
                PUSH: if (n >= D) so = 1'b1; else m_stk.push_back(d);
                POP:  if (n < 1) su = 1'b1; else void'(m_stk.pop_back());
                DUP:  if (n < 1) su = 1'b1; else if (n >= D) so = 1'b1;
                      else m_stk.push_back(m_stk[n-1]);
                SWAP: if (n < 2) su = 1'b1;
                      else begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; end
                OVER: if (n < 2) su = 1'b1; else if (n >= D) so = 1'b1;
                      else m_stk.push_back(m_stk[n-2]);
                REPL: if (n < 1) su = 1'b1; else m_stk[n-1] = d;
                BIN:  if (n < 2) su = 1'b1;
                      else begin void'(m_stk.pop_back()); m_stk[n-2] = d; end
                default: ;
            endcase
        end
        m_ovf = clr ? so : (m_ovf | so);
        m_unf = clr ? su : (m_unf | su);
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        check({tag, ".tos"},   64'(ifc.tos),      64'(e.tos));
        check({tag, ".nos"},   64'(ifc.nos),      64'(e.nos));
        check({tag, ".depth"}, 64'(ifc.depth),    64'(e.depth));
        check({tag, ".empty"}, 64'(ifc.empty),    64'(e.empty));
        check({tag, ".full"},  64'(ifc.full),     64'(e.full));
        check({tag, ".ovf"},   64'(ifc.ovf),      64'(e.ovf));
        check({tag, ".unf"},   64'(ifc.unf),      64'(e.unf));
        check({tag, ".rdy"},   64'(ifc.op_ready), 64'(e.rdy));
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] d,
                         input bit clr);
        exp_t e;
        @(negedge clk);
        ifc.op_valid = 1'b1;
        ifc.op       = o;
        ifc.din      = d;
        ifc.err_clr  = clr;
        model_step(o, d, clr);
        sb.push_back(model_view());
        @(posedge clk);
        #1;
        ifc.op_valid = 1'b0;
        ifc.err_clr  = 1'b0;
        e = sb.pop_front();
        cmp_all(tag, e);
    endtask

    initial begin
        ifc.op_valid = 1'b0;
        ifc.op       = NOP;
        ifc.din      = '0;
        ifc.err_clr  = 1'b0;
        #1;
        cmp_all("reset", model_view());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("push5", PUSH, 36'd5, 1'b0);
        do_op("push7", PUSH, 36'd7, 1'b0);
        do_op("push9", PUSH, 36'd9, 1'b0);
        check("p3.tos_const", 64'(ifc.tos), 64'd9);
        check("p3.nos_const", 64'(ifc.nos), 64'd7);
        do_op("pop1", POP, '0, 1'b0);
        do_op("pop2", POP, '0, 1'b0);
        do_op("pop3", POP, '0, 1'b0);
        check("pop3.empty_const", 64'(ifc.empty), 64'd1);

        for (int i = 1; i <= D; i++) do_op("fill", PUSH, W'(i), 1'b0);
        check("full_const", 64'(ifc.full), 64'd1);
        do_op("ovf_push", PUSH, 36'd99, 1'b0);
        check("ovf_const", 64'(ifc.ovf), 64'd1);
        do_op("ign_pop", POP, '0, 1'b0);
        do_op("clr", NOP, '0, 1'b1);
        do_op("pop_after_clr", POP, '0, 1'b0);
        check("pop_after_clr.tos_const", 64'(ifc.tos), 64'(D - 1));
        for (int i = 0; i < D - 1; i++) do_op("drain", POP, '0, 1'b0);

        do_op("unf_pop", POP, '0, 1'b0);
        do_op("clr2", NOP, '0, 1'b1);
        do_op("push1", PUSH, 36'd1, 1'b0);
        do_op("unf_swap", SWAP, '0, 1'b0);
        check("unf_swap.tos_const", 64'(ifc.tos), 64'd1);
        do_op("clr3", NOP, '0, 1'b1);
        do_op("pop_one", POP, '0, 1'b0);

        do_op("push2", PUSH, 36'd2, 1'b0);
        do_op("push3", PUSH, 36'd3, 1'b0);
        do_op("swap", SWAP, '0, 1'b0);
        do_op("over", OVER, '0, 1'b0);
        do_op("dup", DUP, '0, 1'b0);
        check("dup.depth_const", 64'(ifc.depth), 64'd4);
        for (int i = 0; i < 4; i++) do_op("drain2", POP, '0, 1'b0);

        do_op("push10", PUSH, 36'd10, 1'b0);
        do_op("push20", PUSH, 36'd20, 1'b0);
        do_op("push30", PUSH, 36'd30, 1'b0);
        do_op("bin", BIN, 36'd50, 1'b0);
        check("bin.nos_const", 64'(ifc.nos), 64'd10);
        do_op("repl", REPL, 36'h123, 1'b0);
        do_op("pop_b1", POP, '0, 1'b0);
        do_op("pop_b2", POP, '0, 1'b0);

        for (int i = 1; i <= 5; i++) do_op("pre_rst", PUSH, W'(i * 11), 1'b0);
        @(negedge clk);
        ifc.op_valid = 1'b1;
        ifc.op       = PUSH;
        ifc.din      = 36'd77;
        #2;
        rst = 1'b1;
        #1;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        cmp_all("async_rst", model_view());
        @(negedge clk);
        ifc.op_valid = 1'b0;
        rst = 1'b0;
        cmp_all("after_rst", model_view());
        do_op("push_after_rst", PUSH, 36'd1, 1'b0);

        for (int i = 0; i < 80; i++)
            do_op("rand", 3'($urandom_range(0, 7)), W'({$urandom, $urandom}),
                  ($urandom_range(0, 3) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
